mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one backing memory port (index-based, 64-bit word granularity) between three requesters: instruction fetch (read), backend load and backend store. It sits between the frontend fetch unit, the backend mem stage and the memory/cache port. Arbitration is round-robin, with exactly one transaction outstanding at a time. Requester payloads are latched at grant, so requesters only need to hold them until their ready pulse.

Parameters:
ADDR_W, 64, width of every index bus (64-bit word index).
DATA_W, 64, read/write data width.
MASK_W, 64, write-mask width, one bit per data bit.
TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT before abort; must be >= 2.

Ports:
clock  in  1  clock
reset_n  in  1  asynchronous active-low reset
fetch_valid  in  1  fetch read request
fetch_ready  out  1  one-cycle pulse when the fetch request is granted and latched
fetch_index  in  ADDR_W  fetch word index
fetch_done  out  1  fetch transaction complete (one cycle)
fetch_rdata  out  DATA_W  fetch read data, valid with fetch_done
load_valid / load_ready / load_index / load_done / load_rdata  as fetch, for the load requester
store_valid  in  1  store request
store_ready  out  1  grant pulse
store_index  in  ADDR_W  store word index
store_wdata  in  DATA_W  pre-shifted write data
store_wmask  in  MASK_W  bit write mask
store_done  out  1  store complete (one cycle)
mem_valid  out  1  downstream request valid
mem_ready  in  1  downstream accepts request
mem_write  out  1  1 = store, 0 = read
mem_index  out  ADDR_W  latched index
mem_wdata  out  DATA_W  latched write data; 0 for reads
mem_wmask  out  MASK_W  latched mask; 0 for reads
mem_done  in  1  downstream transaction complete
mem_rdata  in  DATA_W  downstream read data, valid with mem_done
busy  out  1  state != IDLE
timeout_err  out  1  sticky; set on WAIT timeout

Behaviour:
- Reset (async, any state): state = IDLE; rr_ptr = 0; owner, latches and wait counter = 0; timeout_err = 0. All outputs are 0.
- Requester encoding: 0 = fetch, 1 = load, 2 = store. Round-robin search starts at rr_ptr and wraps through 0..2.
- IDLE:
  - If any *_valid is high, the winner is the first valid requester in RR order.
  - The winner's *_ready is high combinationally that cycle. Its index (plus wdata/wmask for store) is latched; mem_write = (winner == 2); owner = winner.
  - Next state is ISSUE. Losers receive no ready and must keep valid asserted.
- ISSUE:
  - mem_valid = 1 with the latched payload, stable until mem_ready.
  - On mem_valid & mem_ready, the wait counter clears and the next state is WAIT.
  - All *_ready stay 0.
- WAIT:
  - mem_valid = 0. The counter increments each cycle.
  - On mem_done:
    - The owner's *_done pulses in the same cycle (combinational).
    - The owner's *_rdata = mem_rdata that cycle; the other rdata outputs are 0.
    - rr_ptr = (owner + 1) mod 3. Next state is IDLE.
  - Timeout: if the counter reaches TIMEOUT_CYCLES - 1 without mem_done:
    - timeout_err is set (sticky until reset).
    - The owner's *_done pulses with rdata = 0.
    - rr_ptr advances as for a normal completion. Next state is IDLE.
  - mem_done outside WAIT is ignored.
- Minimum transaction latency: grant at cycle 0, mem_valid at cycle 1, done no earlier than cycle 2 (mem_ready at 1, mem_done at 2).
- The earliest next grant is the cycle after done. No back-to-back grant occurs in the done cycle.
- Every *_rdata output is 0 whenever its *_done is low.
- Requester valid dropping after grant has no effect; the latched transaction completes.
- A requester must not raise valid again for a new op until after its done.
- Simultaneous valids with rr_ptr = 1 grant in order load, store, fetch, then load again. No requester waits more than two other transactions.

Test Plan:
- Reset with all valids high, then release: fetch_ready pulses in the first IDLE cycle; mem_valid = 1 with mem_write = 0 and mem_index = fetch_index (0x100) one cycle later.
- Store only (index 0x20, wdata 0xAB00, wmask 0xFF00): mem_write = 1 and the latched values appear on mem_*. mem_done at cycle 4 -> store_done = 1 in the same cycle; fetch_done = 0 and load_done = 0.
- All three valid continuously, mem_ready = 1, mem_done two cycles after issue: grant order is fetch, load, store, fetch, with grants 4 cycles apart.
- Load with mem_ready held 0 for 5 cycles: mem_valid and mem_index stay stable for all 5 cycles; load_ready pulses exactly once, at grant.
- TIMEOUT_CYCLES = 8, mem_done never asserted: load_done pulses with load_rdata = 0 after 8 WAIT cycles. timeout_err = 1 and stays 1 while a subsequent fetch completes normally.
- reset_n asserted low mid-WAIT: busy, mem_valid and all *_done go 0 immediately. After release, a mem_done pulse produces no *_done.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch, load and store.
// One transaction in flight; payload is latched at grant, WAIT is bounded by a timeout.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W         = 64,
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned MASK_W         = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              fetch_valid,
    output logic              fetch_ready,
    input  logic [ADDR_W-1:0] fetch_index,
    output logic              fetch_done,
    output logic [DATA_W-1:0] fetch_rdata,

    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_index,
    output logic              load_done,
    output logic [DATA_W-1:0] load_rdata,

    input  logic              store_valid,
    output logic              store_ready,
    input  logic [ADDR_W-1:0] store_index,
    input  logic [DATA_W-1:0] store_wdata,
    input  logic [MASK_W-1:0] store_wmask,
    output logic              store_done,

    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_index,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy,
    output logic              timeout_err
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        rr_q, rr_d;
    logic [1:0]        owner_q, owner_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              terr_q, terr_d;

    logic [2:0]        req_vec;
    logic [1:0]        cand_c;
    logic [1:0]        winner_c;
    logic              grant_c;
    logic              grant_ok;
    logic              done_c;
    logic              timeout_c;

    assign req_vec = {store_valid, load_valid, fetch_valid};

    // First valid requester in round-robin order starting at rr_q.
    always_comb begin
        cand_c   = 2'd0;
        winner_c = 2'd0;
        grant_c  = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            cand_c = 2'((32'(rr_q) + i) % 32'd3);
            if (!grant_c && req_vec[cand_c]) begin
                grant_c  = 1'b1;
                winner_c = cand_c;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        write_d   = write_q;
        index_d   = index_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        cnt_d     = cnt_q;
        terr_d    = terr_q;
        timeout_c = 1'b0;
        done_c    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_c) begin
                    owner_d = winner_c;
                    write_d = (winner_c == 2'd2);
                    wdata_d = '0;
                    wmask_d = '0;
                    case (winner_c)
                        2'd0:    index_d = fetch_index;
                        2'd1:    index_d = load_index;
                        default: begin
                            index_d = store_index;
                            wdata_d = store_wdata;
                            wmask_d = store_wmask;
                        end
                    endcase
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d     = cnt_q + CNT_W'(1);
                timeout_c = !mem_done && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
                done_c    = mem_done || timeout_c;
                if (timeout_c) begin
                    terr_d = 1'b1;
                end
                if (done_c) begin
                    rr_d    = (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            rr_q    <= 2'd0;
            owner_q <= 2'd0;
            write_q <= 1'b0;
            index_q <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            write_q <= write_d;
            index_q <= index_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    // Ready is combinational off valid, so hold it low while reset is asserted.
    assign grant_ok    = reset_n && (state_q == ST_IDLE) && grant_c;
    assign fetch_ready = grant_ok && (winner_c == 2'd0);
    assign load_ready  = grant_ok && (winner_c == 2'd1);
    assign store_ready = grant_ok && (winner_c == 2'd2);

    assign fetch_done  = done_c && (owner_q == 2'd0);
    assign load_done   = done_c && (owner_q == 2'd1);
    assign store_done  = done_c && (owner_q == 2'd2);
    assign fetch_rdata = (fetch_done && mem_done) ? mem_rdata : '0;
    assign load_rdata  = (load_done && mem_done) ? mem_rdata : '0;

    assign mem_valid   = (state_q == ST_ISSUE);
    assign mem_write   = write_q;
    assign mem_index   = index_q;
    assign mem_wdata   = wdata_q;
    assign mem_wmask   = wmask_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against
// a transaction-level model (round-robin rule, reference memory, responder).
module tb_mem_port_arbiter;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned MASK_W = 64;
    localparam int unsigned TO     = 8;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              fetch_valid, fetch_ready, fetch_done;
    logic [ADDR_W-1:0] fetch_index;
    logic [DATA_W-1:0] fetch_rdata;
    logic              load_valid, load_ready, load_done;
    logic [ADDR_W-1:0] load_index;
    logic [DATA_W-1:0] load_rdata;
    logic              store_valid, store_ready, store_done;
    logic [ADDR_W-1:0] store_index;
    logic [DATA_W-1:0] store_wdata;
    logic [MASK_W-1:0] store_wmask;
    logic              mem_valid, mem_ready, mem_write, mem_done;
    logic [ADDR_W-1:0] mem_index;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              busy, timeout_err;

    int n_pass  = 0;
    int n_total = 0;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_index(fetch_index),
        .fetch_done(fetch_done), .fetch_rdata(fetch_rdata),
        .load_valid(load_valid), .load_ready(load_ready), .load_index(load_index),
        .load_done(load_done), .load_rdata(load_rdata),
        .store_valid(store_valid), .store_ready(store_ready), .store_index(store_index),
        .store_wdata(store_wdata), .store_wmask(store_wmask), .store_done(store_done),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
        .mem_index(mem_index), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic apply_reset();
        reset_n     = 1'b0;
        fetch_valid = 1'b0; load_valid = 1'b0; store_valid = 1'b0;
        fetch_index = '0;   load_index = '0;   store_index = '0;
        store_wdata = '0;   store_wmask = '0;
        mem_ready   = 1'b0; mem_done = 1'b0;   mem_rdata = '0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        fetch_valid = 1'b1; load_valid = 1'b1; store_valid = 1'b1;
        fetch_index = 64'h100; load_index = 64'h200; store_index = 64'h300;
        store_wdata = '0; store_wmask = '0;
        mem_ready = 1'b0; mem_done = 1'b0; mem_rdata = '0;
        @(posedge clock); #2;
        n_total++;
        if ({store_ready, load_ready, fetch_ready} !== 3'b000)
            $display("FAIL reset_ready got=%b exp=000", {store_ready, load_ready, fetch_ready});
        else n_pass++;
        n_total++;
        if ({busy, mem_valid, timeout_err, fetch_done, load_done, store_done} !== 6'b0)
            $display("FAIL reset_status got=%b exp=000000",
                     {busy, mem_valid, timeout_err, fetch_done, load_done, store_done});
        else n_pass++;
        n_total++;
        if (mem_index !== 64'h0) $display("FAIL reset_mem_index got=%h exp=0", mem_index);
        else n_pass++;
        @(posedge clock); #1 reset_n = 1'b1;
        @(negedge clock);
        n_total++;
        if ({store_ready, load_ready, fetch_ready} !== 3'b001)
            $display("FAIL reset_first_grant got=%b exp=001", {store_ready, load_ready, fetch_ready});
        else n_pass++;
        @(posedge clock); #1;
        fetch_valid = 1'b0; load_valid = 1'b0; store_valid = 1'b0;
        @(negedge clock);
        n_total++;
        if ({mem_valid, mem_write, mem_index} !== {1'b1, 1'b0, 64'h100})
            $display("FAIL reset_issue got=%b/%b/%h exp=1/0/100", mem_valid, mem_write, mem_index);
        else n_pass++;
    endtask

    task automatic test_store_only();
        apply_reset();
        store_valid = 1'b1; store_index = 64'h20;
        store_wdata = 64'hAB00; store_wmask = 64'hFF00;
        @(negedge clock);
        n_total++;
        if ({store_ready, load_ready, fetch_ready} !== 3'b100)
            $display("FAIL store_grant got=%b exp=100", {store_ready, load_ready, fetch_ready});
        else n_pass++;
        @(posedge clock); #1 store_valid = 1'b0; mem_ready = 1'b1;
        @(negedge clock);
        n_total++;
        if ({mem_valid, mem_write, mem_index, mem_wdata, mem_wmask} !==
            {1'b1, 1'b1, 64'h20, 64'hAB00, 64'hFF00})
            $display("FAIL store_issue got=%b/%b/%h/%h/%h exp=1/1/20/ab00/ff00",
                     mem_valid, mem_write, mem_index, mem_wdata, mem_wmask);
        else n_pass++;
        @(posedge clock); #1 mem_ready = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        n_total++;
        if ({busy, store_done, load_done, fetch_done} !== 4'b1000)
            $display("FAIL store_wait got=%b exp=1000", {busy, store_done, load_done, fetch_done});
        else n_pass++;
        @(posedge clock); #1 mem_done = 1'b1; mem_rdata = 64'hDEAD;
        @(negedge clock);
        n_total++;
        if ({store_done, load_done, fetch_done} !== 3'b100)
            $display("FAIL store_done got=%b exp=100", {store_done, load_done, fetch_done});
        else n_pass++;
        n_total++;
        if ({fetch_rdata, load_rdata} !== 128'h0)
            $display("FAIL store_rdata_zero got=%h/%h exp=0/0", fetch_rdata, load_rdata);
        else n_pass++;
        @(posedge clock); #1 mem_done = 1'b0;
        @(negedge clock);
        n_total++;
        if (busy !== 1'b0) $display("FAIL store_idle busy=%b exp=0", busy);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [2:0] g_vec [4];
        int         g_cyc [4];
        logic [2:0] exp_vec [4];
        int         ng = 0;
        int         issue_cyc = -10;
        exp_vec[0] = 3'b001; exp_vec[1] = 3'b010; exp_vec[2] = 3'b100; exp_vec[3] = 3'b001;
        for (int k = 0; k < 4; k++) begin g_vec[k] = '0; g_cyc[k] = -1; end
        apply_reset();
        fetch_valid = 1'b1; load_valid = 1'b1; store_valid = 1'b1;
        fetch_index = 64'h1; load_index = 64'h2; store_index = 64'h3;
        mem_ready = 1'b1;
        for (int cyc = 0; cyc < 15; cyc++) begin
            mem_done = (cyc == issue_cyc + 2);
            @(negedge clock);
            if ({store_ready, load_ready, fetch_ready} != 3'b000 && ng < 4) begin
                g_vec[ng] = {store_ready, load_ready, fetch_ready};
                g_cyc[ng] = cyc;
                ng++;
            end
            if (mem_valid) issue_cyc = cyc;
            @(posedge clock); #1;
        end
        fetch_valid = 1'b0; load_valid = 1'b0; store_valid = 1'b0; mem_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (g_vec[k] !== exp_vec[k] || g_cyc[k] != 4 * k)
                $display("FAIL rr_grant%0d got=%b@%0d exp=%b@%0d", k, g_vec[k], g_cyc[k], exp_vec[k], 4 * k);
            else n_pass++;
        end
    endtask

    task automatic test_ready_stall();
        int nready = 0;
        apply_reset();
        load_valid = 1'b1; load_index = 64'h40;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clock);
            if (load_ready) nready++;
            if (c >= 1) begin
                n_total++;
                if ({mem_valid, mem_index} !== {1'b1, 64'h40})
                    $display("FAIL stall_hold c=%0d got=%b/%h exp=1/40", c, mem_valid, mem_index);
                else n_pass++;
            end
            @(posedge clock); #1;
            if (c == 5) mem_ready = 1'b1;
        end
        mem_ready = 1'b0; load_valid = 1'b0; mem_done = 1'b1; mem_rdata = 64'h1234;
        @(negedge clock);
        if (load_ready) nready++;
        n_total++;
        if (nready != 1) $display("FAIL stall_ready_count got=%0d exp=1", nready);
        else n_pass++;
        n_total++;
        if ({load_done, load_rdata, fetch_rdata} !== {1'b1, 64'h1234, 64'h0})
            $display("FAIL stall_done got=%b/%h/%h exp=1/1234/0", load_done, load_rdata, fetch_rdata);
        else n_pass++;
        @(posedge clock); #1 mem_done = 1'b0;
    endtask

    task automatic test_timeout();
        int early = 0;
        apply_reset();
        load_valid = 1'b1; load_index = 64'h55;
        mem_rdata = 64'hFFFF_0000_1111_2222;
        @(posedge clock); #1 load_valid = 1'b0; mem_ready = 1'b1;
        @(posedge clock); #1 mem_ready = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            @(negedge clock);
            if (load_done) early++;
            @(posedge clock); #1;
        end
        @(negedge clock);
        n_total++;
        if (early != 0) $display("FAIL timeout_early got=%0d exp=0", early);
        else n_pass++;
        n_total++;
        if ({load_done, load_rdata} !== {1'b1, 64'h0})
            $display("FAIL timeout_done got=%b/%h exp=1/0", load_done, load_rdata);
        else n_pass++;
        @(posedge clock); #1 fetch_valid = 1'b1; fetch_index = 64'h66;
        @(negedge clock);
        n_total++;
        if ({timeout_err, busy, fetch_ready} !== 3'b101)
            $display("FAIL timeout_sticky got=%b exp=101", {timeout_err, busy, fetch_ready});
        else n_pass++;
        @(posedge clock); #1 fetch_valid = 1'b0; mem_ready = 1'b1;
        @(posedge clock); #1 mem_ready = 1'b0; mem_done = 1'b1; mem_rdata = 64'h7777;
        @(negedge clock);
        n_total++;
        if ({fetch_done, fetch_rdata, timeout_err} !== {1'b1, 64'h7777, 1'b1})
            $display("FAIL timeout_next_fetch got=%b/%h/%b exp=1/7777/1", fetch_done, fetch_rdata, timeout_err);
        else n_pass++;
        @(posedge clock); #1 mem_done = 1'b0;
        @(negedge clock);
        n_total++;
        if (timeout_err !== 1'b1) $display("FAIL timeout_hold got=%b exp=1", timeout_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        fetch_valid = 1'b1; fetch_index = 64'h10;
        @(posedge clock); #1 fetch_valid = 1'b0; mem_ready = 1'b1;
        @(posedge clock); #1 mem_ready = 1'b0;
        @(negedge clock);
        n_total++;
        if (busy !== 1'b1) $display("FAIL midreset_pre busy=%b exp=1", busy);
        else n_pass++;
        #1 reset_n = 1'b0; mem_done = 1'b1; mem_rdata = 64'hABCD;
        #1;
        n_total++;
        if ({busy, mem_valid, fetch_done, load_done, store_done, timeout_err} !== 6'b0 || fetch_rdata !== 64'h0)
            $display("FAIL midreset_async got=%b/%h exp=000000/0",
                     {busy, mem_valid, fetch_done, load_done, store_done, timeout_err}, fetch_rdata);
        else n_pass++;
        @(posedge clock); #1 reset_n = 1'b1;
        @(negedge clock);
        n_total++;
        if ({fetch_done, load_done, store_done, busy} !== 4'b0 || fetch_rdata !== 64'h0)
            $display("FAIL midreset_stray_done got=%b/%h exp=0000/0",
                     {fetch_done, load_done, store_done, busy}, fetch_rdata);
        else n_pass++;
        @(posedge clock); #1 mem_done = 1'b0;
    endtask

    // Reference memory (requester view) and responder memory (port view).
    logic [63:0] ref_mem  [logic [63:0]];
    logic [63:0] resp_mem [logic [63:0]];

    function automatic logic [63:0] init_word(input logic [63:0] idx);
        return {~idx[31:0], idx[31:0] ^ 32'h5A5A_5A5A};
    endfunction

    function automatic logic [63:0] ref_read(input logic [63:0] idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
    endfunction

    function automatic logic [63:0] resp_read(input logic [63:0] idx);
        return resp_mem.exists(idx) ? resp_mem[idx] : init_word(idx);
    endfunction

    task automatic test_random();
        logic [2:0]  req_on, req_gnt, exp_rdy, exp_done;
        logic [63:0] r_idx [3];
        logic [63:0] r_wd  [3];
        logic [63:0] r_wm  [3];
        logic        m_busy, m_issue, m_write, rsp_busy, rsp_fire;
        int          m_owner, m_last, rsp_wait, n_done, w;
        logic [63:0] m_idx, m_wd, m_wm, rsp_data, exp_f, exp_l, cur;
        apply_reset();
        ref_mem.delete(); resp_mem.delete();
        req_on = '0; req_gnt = '0;
        m_busy = 1'b0; m_issue = 1'b0; m_write = 1'b0; m_owner = 0; m_last = 2;
        m_idx = '0; m_wd = '0; m_wm = '0;
        rsp_busy = 1'b0; rsp_wait = 0; rsp_data = '0; n_done = 0;
        for (int r = 0; r < 3; r++) begin r_idx[r] = '0; r_wd[r] = '0; r_wm[r] = '0; end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int r = 0; r < 3; r++) begin
                if (!req_on[r] && !req_gnt[r] && $urandom_range(2) == 0) begin
                    req_on[r] = 1'b1;
                    r_idx[r]  = 64'($urandom_range(7));
                    r_wd[r]   = {$urandom, $urandom};
                    r_wm[r]   = {$urandom, $urandom};
                end
            end
            fetch_valid = req_on[0]; fetch_index = r_idx[0];
            load_valid  = req_on[1]; load_index  = r_idx[1];
            store_valid = req_on[2]; store_index = r_idx[2];
            store_wdata = r_wd[2];   store_wmask = r_wm[2];
            mem_ready   = 1'($urandom_range(1));
            rsp_fire    = rsp_busy && rsp_wait == 0;
            if (rsp_busy && rsp_wait != 0) rsp_wait--;
            if (rsp_fire) begin
                mem_done = 1'b1; mem_rdata = rsp_data;
            end else begin
                mem_done = !rsp_busy && ($urandom_range(7) == 0);
                mem_rdata = {$urandom, $urandom};
            end
            @(negedge clock);
            exp_rdy = '0;
            if (!m_busy) begin
                for (int i = 0; i < 3; i++) begin
                    w = (m_last + 1 + i) % 3;
                    if (req_on[w] && exp_rdy == 3'b000) exp_rdy[w] = 1'b1;
                end
            end
            n_total++;
            if ({store_ready, load_ready, fetch_ready} !== exp_rdy)
                $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, {store_ready, load_ready, fetch_ready}, exp_rdy);
            else n_pass++;
            n_total++;
            if ({busy, mem_valid} !== {m_busy, m_issue})
                $display("FAIL rand_state cyc=%0d got=%b exp=%b", cyc, {busy, mem_valid}, {m_busy, m_issue});
            else n_pass++;
            if (m_issue) begin
                n_total++;
                if ({mem_write, mem_index, mem_wdata, mem_wmask} !==
                    {m_write, m_idx, m_write ? m_wd : 64'h0, m_write ? m_wm : 64'h0})
                    $display("FAIL rand_payload cyc=%0d got=%b/%h/%h/%h exp=%b/%h", cyc,
                             mem_write, mem_index, mem_wdata, mem_wmask, m_write, m_idx);
                else n_pass++;
            end
            exp_done = rsp_fire ? 3'(3'b001 << m_owner) : 3'b000;
            exp_f = (rsp_fire && m_owner == 0) ? ref_read(m_idx) : 64'h0;
            exp_l = (rsp_fire && m_owner == 1) ? ref_read(m_idx) : 64'h0;
            n_total++;
            if ({store_done, load_done, fetch_done} !== exp_done || fetch_rdata !== exp_f || load_rdata !== exp_l)
                $display("FAIL rand_done cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc,
                         {store_done, load_done, fetch_done}, fetch_rdata, load_rdata, exp_done, exp_f, exp_l);
            else n_pass++;
            if (rsp_fire) begin
                if (m_write) begin
                    cur = ref_read(m_idx);
                    ref_mem[m_idx] = (cur & ~m_wm) | (m_wd & m_wm);
                end
                m_busy = 1'b0; m_last = m_owner; req_gnt[m_owner] = 1'b0;
                rsp_busy = 1'b0; n_done++;
            end
            if (m_issue && mem_ready) begin
                m_issue  = 1'b0;
                rsp_busy = 1'b1;
                rsp_wait = $urandom_range(3);
                if (mem_write) begin
                    cur = resp_read(mem_index);
                    resp_mem[mem_index] = (cur & ~mem_wmask) | (mem_wdata & mem_wmask);
                end else begin
                    rsp_data = resp_read(mem_index);
                end
            end
            if (exp_rdy != 3'b000) begin
                m_owner = exp_rdy[0] ? 0 : (exp_rdy[1] ? 1 : 2);
                m_busy = 1'b1; m_issue = 1'b1; m_write = (m_owner == 2);
                m_idx = r_idx[m_owner]; m_wd = r_wd[m_owner]; m_wm = r_wm[m_owner];
                req_on[m_owner] = 1'b0; req_gnt[m_owner] = 1'b1;
            end
            @(posedge clock); #1;
        end
        n_total++;
        if (n_done < 40) $display("FAIL rand_progress got=%0d exp>=40", n_done);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_store_only();
        test_round_robin();
        test_ready_stall();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
